// File: rtl/uart_output_port.sv
// Memory-mapped UART output port: 4-byte register window, TX FIFO and 8N1 serializer.
// Define UART_OUTPUT_PORT_PARITY_EN to add a parity bit (CTRL bit3 selects odd parity).
module uart_output_port #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] output_address,
    input  logic [31:0] output_out,
    input  logic [1:0]  output_size,
    input  logic        output_write_enable,
    output logic [31:0] output_in,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [2:0]    lane_lo, lane_len, lane_hi;
    logic          wr_lane0, wr_lane1;
    logic [7:0]    ctrl_wdata;
    logic          flush, ovf_clr, push_ok, ovf_set, pop, can_start;
    logic          fifo_empty, fifo_full, busy;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          enable_q, enable_d;
    logic          parity_odd_q;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;

    logic [8:0]    count_ext;
    logic [7:0]    status_rd, ctrl_rd, count_rd;
    logic          unused_bits;

    assign unused_bits = ^{output_address[31:2], output_out[31:16]};

    // Byte lanes touched by this access: offset .. offset + bytes - 1.
    always_comb begin
        lane_lo = {1'b0, output_address[1:0]};
        case (output_size)
            2'b01:   lane_len = 3'd2;
            2'b10:   lane_len = 3'd4;
            default: lane_len = 3'd1;
        endcase
        lane_hi  = lane_lo + lane_len - 3'd1;
        wr_lane0 = output_write_enable && (lane_lo == 3'd0);
        wr_lane1 = output_write_enable && (lane_lo <= 3'd1) && (lane_hi >= 3'd1);
    end

    assign ctrl_wdata = output_out[15:8];
    assign flush      = wr_lane1 && ctrl_wdata[1];
    assign ovf_clr    = wr_lane1 && ctrl_wdata[2];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    assign can_start  = enable_q && !fifo_empty && !flush;
    assign push_ok    = wr_lane0 && !flush && (!fifo_full || pop);
    assign ovf_set    = wr_lane0 && !flush && fifo_full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop);
        end
        // A push that overflows beats a same-cycle clear.
        overflow_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
        enable_d   = wr_lane1 ? ctrl_wdata[0] : enable_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            enable_q   <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            enable_q   <= enable_d;
        end
    end

`ifdef UART_OUTPUT_PORT_PARITY_EN
    logic parity_odd_d;
    assign parity_odd_d = wr_lane1 ? ctrl_wdata[3] : parity_odd_q;

    always_ff @(posedge clk) begin
        if (!rst_n) parity_odd_q <= 1'b0;
        else        parity_odd_q <= parity_odd_d;
    end
`else
    assign parity_odd_q = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= output_out[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        if (pop) begin
            state_d = S_START;
            baud_d  = BAUD_RELOAD;
            bit_d   = 3'd0;
            data_d  = mem_q[rd_ptr_q];
        end else if (state_q != S_IDLE) begin
            if (baud_q != '0) begin
                baud_d = baud_q - BW'(1);
            end else begin
                baud_d = BAUD_RELOAD;
                case (state_q)
                    S_START: state_d = S_DATA;
                    S_DATA: begin
                        if (bit_q == 3'd7) begin
`ifdef UART_OUTPUT_PORT_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                    S_PARITY: state_d = S_STOP;
                    default:  state_d = S_IDLE;
                endcase
            end
        end
    end

    // A frame may start from IDLE or straight out of the last STOP cycle.
    always_comb begin
        pop  = can_start && ((state_q == S_IDLE) || ((state_q == S_STOP) && (baud_q == '0)));
        busy = (state_q != S_IDLE);
        case (state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = data_q[bit_q];
            S_PARITY: tx = (^data_q) ^ parity_odd_q;
            default:  tx = 1'b1;
        endcase
    end

    always_comb begin
        count_ext = 9'(count_q);
        count_rd  = count_ext[8] ? 8'hFF : count_ext[7:0];
        status_rd = {4'b0000, overflow_q, busy, fifo_empty, fifo_full};
        ctrl_rd   = {4'b0000, parity_odd_q, 2'b00, enable_q};
        output_in = {8'h00, count_rd, ctrl_rd, status_rd} >> {output_address[1:0], 3'b000};
    end

endmodule

// File: tb/tb_uart_output_port.sv
// Randomized scoreboard bench for uart_output_port: a queue model of the FIFO feeds
// expected bytes to a monitor that decodes frames from the tx line.
module tb_uart_output_port;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef UART_OUTPUT_PORT_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] output_address;
    logic [31:0] output_out;
    logic [1:0]  output_size;
    logic        output_write_enable;
    logic [31:0] output_in;
    logic        tx;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  fifo_m[$];
    bit          ovf_m, en_m, par_m;
    bit          mon_busy;
    int          frames_seen = 0;
    logic [10:0] last_frame;

    logic [10:0] fbits, expf;
    logic [7:0]  e_byte;
    bit          have, aborted;

    uart_output_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .output_address      (output_address),
        .output_out          (output_out),
        .output_size         (output_size),
        .output_write_enable (output_write_enable),
        .output_in           (output_in),
        .tx                  (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        fifo_m.delete();
        ovf_m = 0;
        en_m  = 1;
        par_m = 0;
    endtask

    // Register-level model of a write: lanes offset..offset+bytes-1.
    task automatic model_write(input int off, input int sz, input logic [31:0] d);
        int  nbytes;
        bit  lane0, lane1;
        nbytes = (sz == 3) ? 1 : (1 << sz);
        lane0  = (off == 0);
        lane1  = (off <= 1) && (off + nbytes - 1 >= 1);
        if (lane1) begin
            en_m = d[8];
`ifdef UART_OUTPUT_PORT_PARITY_EN
            par_m = d[11];
`endif
            if (d[10]) ovf_m = 0;
        end
        if (lane1 && d[9]) fifo_m.delete();
        else if (lane0) begin
            if (fifo_m.size() < DEPTH) fifo_m.push_back(d[7:0]);
            else ovf_m = 1;
        end
    endtask

    function automatic logic [31:0] model_word(input bit busy_exp);
        logic [7:0] st, ct, cn;
        cn = 8'(fifo_m.size());
        st = {4'b0, ovf_m, busy_exp, fifo_m.size() == 0, fifo_m.size() == DEPTH};
        ct = {4'b0, par_m, 2'b00, en_m};
        return {8'h00, cn, ct, st};
    endfunction

    task automatic wr(input int off, input int sz, input logic [31:0] d);
        @(posedge clk);
        #1;
        output_address      = 32'(off);
        output_size         = 2'(sz);
        output_out          = d;
        output_write_enable = 1'b1;
        model_write(off, sz, d);
        @(posedge clk);
        #1;
        output_write_enable = 1'b0;
    endtask

    task automatic rd(input int off, output logic [31:0] v);
        @(posedge clk);
        #1;
        output_address = 32'(off);
        @(negedge clk);
        v = output_in;
    endtask

    task automatic check_regs(input string nm);
        logic [31:0] v;
        rd(0, v);
        check(nm, v, model_word(1'b0));
    endtask

    task automatic drain(input string nm);
        int i;
        for (i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (fifo_m.size() == 0 && !mon_busy && tx === 1'b1) break;
        end
        check(nm, 32'(i >= 4000), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_tx_idle(input string nm, input int cycles);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check(nm, 32'(lows), 32'd0);
    endtask

    // Frame monitor: decodes each frame at mid-bit and compares with the model's head byte.
    initial begin : monitor
        mon_busy = 0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                mon_busy = 1;
                aborted  = 0;
                fbits    = '0;
                have     = (fifo_m.size() > 0);
                e_byte   = have ? fifo_m.pop_front() : 8'h00;
                for (int c = 0; c < NB * CPB; c++) begin
                    if (c > 0) @(negedge clk);
                    if (rst_n !== 1'b1) aborted = 1;
                    if (c % CPB == CPB / 2) fbits[c / CPB] = tx;
                end
                if (!aborted) begin
                    expf = '0;
                    expf[8:1] = e_byte;
`ifdef UART_OUTPUT_PORT_PARITY_EN
                    expf[9]  = (^e_byte) ^ par_m;
                    expf[10] = 1'b1;
`else
                    expf[9]  = 1'b1;
`endif
                    check("frame_expected", 32'(have), 32'd1);
                    check("frame_bits", 32'(fbits), 32'(expf));
                    last_frame = fbits;
                    frames_seen++;
                end
                mon_busy = 0;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, n_bad %0d", n_bad);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] v;
        int          n, busy_cnt, fs0;
        logic [7:0]  b;

        rst_n = 1'b0;
        output_address = '0;
        output_out = '0;
        output_size = '0;
        output_write_enable = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("tx_in_reset", 32'(tx), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state through every read offset.
        rd(0, v); check("reset_off0", v, 32'h0000_0102);
        rd(1, v); check("reset_off1", v, 32'h0000_0001);
        rd(2, v); check("reset_off2", v, 32'h0000_0000);
        rd(3, v); check("reset_off3", v, 32'h0000_0000);
        check_tx_idle("reset_tx_idle", 20);

        // Single 0xA5 frame and its busy duration.
        wr(0, 0, 32'h0000_00A5);
        output_address = 32'd0;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (output_in[2]) busy_cnt++;
        end
        check("busy_cycles", 32'(busy_cnt), 32'(NB * CPB));
        drain("drain_a5");
`ifdef UART_OUTPUT_PORT_PARITY_EN
        check("a5_wave", 32'(last_frame), 32'b1_0_10100101_0);
`else
        check("a5_wave", 32'(last_frame[9:0]), 32'b1_10100101_0);
`endif
        check_regs("idle_after_a5");

        // Disabled overfill, then overflow with a same-cycle clear, then clear and send.
        wr(1, 0, 32'h0000_0000);
        for (int i = 0; i < 9; i++) wr(0, 0, 32'($urandom_range(0, 255)));
        check_regs("overfill");
        wr(0, 2, {16'h0000, 8'h04, 8'($urandom_range(0, 255))});
        check_regs("ovf_set_wins");
        wr(1, 0, 32'h0000_0500);
        rd(0, v); check("ovf_cleared", 32'(v[3]), 32'd0);
        rd(1, v); check("ctrl_enable", 32'(v[7:0]), 32'h01);
        drain("drain_overfill");
        check_regs("idle_after_overfill");

        // Word write with flush discards the same-cycle push.
        fs0 = frames_seen;
        wr(0, 2, 32'h0000_0355);
        check_tx_idle("flush_word_tx_idle", 60);
        check_regs("flush_word_regs");
        check("flush_word_no_frame", 32'(frames_seen), 32'(fs0));

        // Flush of a populated FIFO.
        wr(1, 0, 32'h0000_0000);
        for (int i = 0; i < 4; i++) wr(0, 0, 32'($urandom_range(0, 255)));
        check_regs("pre_flush");
        wr(1, 0, 32'h0000_0200);
        check_regs("post_flush");
        wr(1, 0, 32'h0000_0100);
        check_tx_idle("post_flush_idle", 80);
        check("post_flush_no_frame", 32'(frames_seen), 32'(fs0));

        // CTRL bit3 is parity_odd only in the parity build.
        wr(1, 0, 32'h0000_0900);
        rd(1, v); check("ctrl_bit3", 32'(v[7:0]), 32'(model_word(1'b0) >> 8) & 32'hFF);
        wr(1, 0, 32'h0000_0100);

        // Randomized disabled fill rounds.
        for (int r = 0; r < 6; r++) begin
            wr(1, 0, 32'h0000_0000);
            n = $urandom_range(0, 11);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) wr(0, 1, {16'h0000, 8'h00, b});
                else wr(0, 0, {24'h0, b});
            end
            check_regs("round_fill");
            wr(1, 0, 32'h0000_0500);
            drain("round_drain");
            check_regs("round_idle");
        end

        // Enabled streaming with random gaps.
        for (int i = 0; i < DEPTH; i++) begin
            wr(0, 0, 32'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 60)) @(posedge clk);
        end
        drain("stream_drain");
        check_regs("stream_idle");

        // Reset in the middle of a frame's data bits.
        wr(1, 0, 32'h0000_0000);
        for (int i = 0; i < 3; i++) wr(0, 0, 32'($urandom_range(0, 255)));
        wr(1, 0, 32'h0000_0100);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin n = 1; break; end
        end
        check("reset_test_start", 32'(n), 32'd1);
        repeat (3 * CPB) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("tx_after_reset", 32'(tx), 32'd1);
        fs0 = frames_seen;
        rd(0, v); check("regs_after_reset", v, 32'h0000_0102);
        check_tx_idle("no_frames_after_reset", 200);
        check("no_frame_count_after_reset", 32'(frames_seen), 32'(fs0));

`ifdef UART_OUTPUT_PORT_PARITY_EN
        wr(0, 0, 32'h0000_0007);
        drain("parity_even_drain");
        check("parity_even_bit", 32'(last_frame[9]), 32'd1);
        wr(1, 0, 32'h0000_0900);
        wr(0, 0, 32'h0000_0007);
        drain("parity_odd_drain");
        check("parity_odd_bit", 32'(last_frame[9]), 32'd0);
        check("parity_stop_bit", 32'(last_frame[10]), 32'd1);
`endif

        check("model_empty_at_end", 32'(fifo_m.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
